// File: rtl/bcd_cascade_counter.sv
// Synchronous DIGITS-digit BCD up/down counter with load, top-digit limit and tc/co cascade outputs.
// cnt/co update one clk after en/load/rst are sampled; tc is zero-latency. There is no backpressure: en gates each step.
module bcd_cascade_counter #(
    parameter int DIGITS    = 3,
    parameter int TOP_LIMIT = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] cnt,
    output logic                tc,
    output logic                co
);

    localparam int W = 4*DIGITS;

    logic [W-1:0]    r_cnt;
    logic            r_co;
    logic [W-1:0]    w_step;
    logic [W-1:0]    w_load_san;
    // w_all_max[i] / w_all_zero[i]: every digit below i sits at its max / at zero.
    logic [DIGITS:0] w_all_max;
    logic [DIGITS:0] w_all_zero;

    assign w_all_max[0]  = 1'b1;
    assign w_all_zero[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam logic [3:0] DMAX = (i == DIGITS-1) ? 4'(TOP_LIMIT) : 4'd9;

        logic [3:0] w_d;
        logic [3:0] w_ld;
        logic       w_at_max;
        logic       w_at_zero;

        assign w_d       = r_cnt[4*i +: 4];
        assign w_ld      = load_val[4*i +: 4];
        assign w_at_max  = (w_d == DMAX);
        assign w_at_zero = (w_d == 4'd0);

        assign w_all_max[i+1]  = w_all_max[i]  & w_at_max;
        assign w_all_zero[i+1] = w_all_zero[i] & w_at_zero;

        assign w_load_san[4*i +: 4] = (w_ld > DMAX) ? 4'd0 : w_ld;

        always_comb begin
            w_step[4*i +: 4] = w_d;
            if (up) begin
                if (w_all_max[i])
                    w_step[4*i +: 4] = w_at_max ? 4'd0 : w_d + 4'd1;
            end else begin
                if (w_all_zero[i])
                    w_step[4*i +: 4] = w_at_zero ? DMAX : w_d - 4'd1;
            end
        end
    end

    // Terminal value for the current direction; also the wrap condition for co.
    assign tc = en & (up ? w_all_max[DIGITS] : w_all_zero[DIGITS]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_co  <= 1'b0;
        end else if (load) begin
            r_cnt <= w_load_san;
            r_co  <= 1'b0;
        end else if (en) begin
            r_cnt <= w_step;
            r_co  <= tc;
        end else begin
            r_co  <= 1'b0;
        end
    end

    assign cnt = r_cnt;
    assign co  = r_co;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed bench: 3-digit counter, 2-digit 00..59 counter, and two cascaded 3-digit stages.
module tb_bcd_cascade_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 3-digit, top limit 9
    logic        a_rst, a_en, a_up, a_load;
    logic [11:0] a_lval, a_cnt;
    logic        a_tc, a_co;

    // 2-digit, top limit 5
    logic        b_rst, b_en, b_up, b_load;
    logic [7:0]  b_lval, b_cnt;
    logic        b_tc, b_co;

    // cascaded pair
    logic        c_rst, c_en, c_up, c_load;
    logic [11:0] c_lval_lo, c_lval_hi, lo_cnt, hi_cnt;
    logic        lo_tc, lo_co, hi_tc, hi_co;

    bcd_cascade_counter #(.DIGITS(3), .TOP_LIMIT(9)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_lval), .cnt(a_cnt), .tc(a_tc), .co(a_co));

    bcd_cascade_counter #(.DIGITS(2), .TOP_LIMIT(5)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load),
        .load_val(b_lval), .cnt(b_cnt), .tc(b_tc), .co(b_co));

    bcd_cascade_counter #(.DIGITS(3), .TOP_LIMIT(9)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load),
        .load_val(c_lval_lo), .cnt(lo_cnt), .tc(lo_tc), .co(lo_co));

    bcd_cascade_counter #(.DIGITS(3), .TOP_LIMIT(9)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .up(c_up), .load(c_load),
        .load_val(c_lval_hi), .cnt(hi_cnt), .tc(hi_tc), .co(hi_co));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge, away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int lo_co_n;
    int hi_co_n;

    initial begin
        a_rst = 1; a_en = 1; a_up = 1; a_load = 1; a_lval = 12'h123;
        b_rst = 1; b_en = 0; b_up = 1; b_load = 0; b_lval = 8'h00;
        c_rst = 1; c_en = 0; c_up = 1; c_load = 0; c_lval_lo = 12'h000; c_lval_hi = 12'h000;
        #2;

        // Reset wins over load and en.
        tick(); tick();
        chk("rst_cnt", a_cnt, 12'h000);
        chk("rst_co", a_co, 1'b0);
        chk("rst_tc_up", a_tc, 1'b0);
        a_up = 0; #1;
        chk("rst_tc_down", a_tc, 1'b1);
        a_up = 1; a_load = 0;
        a_en = 0; #1;
        chk("rst_tc_en0", a_tc, 1'b0);
        a_en = 1;

        // Release reset: count up.
        a_rst = 0;
        tick(); chk("up_001", a_cnt, 12'h001);
        tick(); chk("up_002", a_cnt, 12'h002);
        tick(); chk("up_003", a_cnt, 12'h003);
        chk("up_co0", a_co, 1'b0);

        // Up wrap from 998.
        a_load = 1; a_lval = 12'h998; a_en = 0;
        tick(); chk("ld_998", a_cnt, 12'h998);
        a_load = 0; a_en = 1;
        tick(); chk("up_999", a_cnt, 12'h999);
        chk("tc_999", a_tc, 1'b1);
        tick(); chk("wrap_000", a_cnt, 12'h000);
        chk("wrap_co", a_co, 1'b1);
        tick(); chk("post_001", a_cnt, 12'h001);
        chk("post_co", a_co, 1'b0);

        // Down wrap from 000, then borrow across digits.
        a_load = 1; a_lval = 12'h000;
        tick(); chk("ld_000", a_cnt, 12'h000);
        a_load = 0; a_up = 0; #1;
        chk("tc_dn_000", a_tc, 1'b1);
        tick(); chk("dn_999", a_cnt, 12'h999);
        chk("dn_co", a_co, 1'b1);
        tick(); chk("dn_998", a_cnt, 12'h998);
        chk("dn_co0", a_co, 1'b0);
        a_load = 1; a_lval = 12'h990;
        tick();
        a_load = 0;
        tick(); chk("dn_989", a_cnt, 12'h989);

        // Load beats a would-be wrap.
        a_up = 1; a_load = 1; a_lval = 12'h999;
        tick();
        a_lval = 12'h456;
        tick(); chk("ld_over_wrap", a_cnt, 12'h456);
        chk("ld_over_wrap_co", a_co, 1'b0);

        // Hold with en low.
        a_load = 0; a_en = 0;
        tick(); chk("hold_456", a_cnt, 12'h456);

        // Reset mid-count.
        a_load = 1; a_lval = 12'h537;
        tick();
        a_load = 0; a_en = 1; a_rst = 1;
        tick(); chk("rst_mid", a_cnt, 12'h000);
        chk("rst_mid_co", a_co, 1'b0);
        a_rst = 0; a_en = 0;

        // 00..59 counter.
        b_rst = 0; b_load = 1; b_lval = 8'h59;
        tick(); chk("b_ld_59", b_cnt, 8'h59);
        chk("b_tc_en0", b_tc, 1'b0);
        b_load = 0; b_en = 1; b_up = 1; #1;
        chk("b_tc_59", b_tc, 1'b1);
        tick(); chk("b_wrap_00", b_cnt, 8'h00);
        chk("b_wrap_co", b_co, 1'b1);
        b_en = 0; b_load = 1; b_lval = 8'h7C;
        tick(); chk("b_san_7C", b_cnt, 8'h00);
        b_lval = 8'h3C;
        tick(); chk("b_san_3C", b_cnt, 8'h30);
        b_lval = 8'h00;
        tick();
        b_load = 0; b_en = 1; b_up = 0;
        tick(); chk("b_dn_59", b_cnt, 8'h59);
        chk("b_dn_co", b_co, 1'b1);
        tick(); chk("b_dn_58", b_cnt, 8'h58);
        b_en = 0;

        // Cascade: 000_999 + 999 -> 001_998.
        c_rst = 0; c_load = 1; c_lval_hi = 12'h000; c_lval_lo = 12'h999;
        tick();
        chk("c_ld", {hi_cnt, lo_cnt}, 24'h000999);
        c_load = 0; c_en = 1; c_up = 1;
        lo_co_n = 0; hi_co_n = 0;
        for (int k = 0; k < 999; k++) begin
            tick();
            if (lo_co) lo_co_n++;
            if (hi_co) hi_co_n++;
        end
        chk("c_999_steps", {hi_cnt, lo_cnt}, 24'h001998);
        chk("c_lo_co_once", lo_co_n, 1);
        chk("c_hi_co_quiet", hi_co_n, 0);

        // Cascade full wrap.
        c_en = 0; c_load = 1; c_lval_hi = 12'h999; c_lval_lo = 12'h999;
        tick();
        c_load = 0; c_en = 1;
        tick(); chk("c_wrap", {hi_cnt, lo_cnt}, 24'h000000);
        chk("c_wrap_hi_co", hi_co, 1'b1);
        tick(); chk("c_after", {hi_cnt, lo_cnt}, 24'h000001);
        chk("c_after_hi_co", hi_co, 1'b0);

        // Cascade borrow: 001_000 - 1 -> 000_999.
        c_en = 0; c_load = 1; c_lval_hi = 12'h001; c_lval_lo = 12'h000;
        tick();
        c_load = 0; c_en = 1; c_up = 0;
        tick(); chk("c_borrow", {hi_cnt, lo_cnt}, 24'h000999);
        chk("c_borrow_hi_co", hi_co, 1'b0);
        c_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
